// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO pointer blocks (read and write side).
// Gray/binary helpers are width-agnostic: callers zero-extend to FUNC_W and cast back.
package async_fifo_pkg;

    localparam int unsigned FIFO_ADDR_SIZE = 4;
    localparam int unsigned FUNC_W         = 32;

    typedef logic [FIFO_ADDR_SIZE:0]   ptr_t;
    typedef logic [FIFO_ADDR_SIZE-1:0] addr_t;

    // Registered read-side status bits kept together so reset and update stay in step.
    typedef struct packed {
        logic mem_empty;
        logic valid;
        logic almost_empty;
        logic underflow;
    } rd_status_t;

    localparam rd_status_t RD_STATUS_RESET = '{
        mem_empty:    1'b1,
        valid:        1'b0,
        almost_empty: 1'b1,
        underflow:    1'b0
    };

    function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Leading zeros of a zero-extended code do not disturb the prefix XOR.
    function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] gray);
        logic [FUNC_W-1:0] bin;
        bin = gray;
        for (int i = 1; i < FUNC_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter: bit i is the XOR of all Gray bits at or above i.
module gray2bin_conv #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/rptr_empty_level.sv
// Read-side pointer/status controller for the async FIFO: empty, occupancy, almost-empty,
// sticky underflow, and an optional first-word-fall-through output stage.
module rptr_empty_level
    import async_fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = FIFO_ADDR_SIZE,
    parameter int unsigned FWFT      = 0
) (
    input  logic                 rd_clk,
    input  logic                 rd_rstn,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE:0]   ae_thresh,
    input  logic [ADDR_SIZE:0]   wr_ptr_gray_sync,
    output logic                 mem_ren,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr_gray,
    output logic                 rempty,
    output logic                 rvalid,
    output logic                 ralmost_empty,
    output logic [ADDR_SIZE:0]   rlevel,
    output logic                 runderflow
);

    typedef logic [ADDR_SIZE:0] rptr_t;

    rptr_t      rbin_q, rbin_d;
    rptr_t      rgray_q, rgray_d;
    rptr_t      rlevel_q, rlevel_d;
    rptr_t      wbin;
    rptr_t      valid_adj;
    rd_status_t status_q, status_d;
    logic       ren;
    logic       rempty_cur;

    gray2bin_conv #(
        .WIDTH(ADDR_SIZE + 1)
    ) u_wr_g2b (
        .gray_i(wr_ptr_gray_sync),
        .bin_o (wbin)
    );

    always_comb begin
        ren        = 1'b0;
        rempty_cur = status_q.mem_empty;
        status_d   = status_q;
        valid_adj  = '0;

        if (FWFT != 0) begin
            // Refill the output stage whenever it is empty or being consumed this cycle.
            ren            = ~status_q.mem_empty & (~status_q.valid | rd_en);
            rempty_cur     = ~status_q.valid;
            status_d.valid = ren | (status_q.valid & ~rd_en);
        end else begin
            ren = rd_en & ~status_q.mem_empty;
        end

        rbin_d  = rbin_q + {{ADDR_SIZE{1'b0}}, ren};
        rgray_d = rptr_t'(bin2gray(FUNC_W'(rbin_d)));

        status_d.mem_empty = (rgray_d == wr_ptr_gray_sync);
        if (FWFT == 0) begin
            status_d.valid = ~status_d.mem_empty;
        end

        // Next-state based so that level 0 and empty assert on the same edge.
        if (FWFT != 0) begin
            valid_adj[0] = status_d.valid;
        end
        rlevel_d = (wbin - rbin_d) + valid_adj;

        status_d.almost_empty = (rlevel_d <= ae_thresh);
        status_d.underflow    = status_q.underflow | (rd_en & rempty_cur);
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            rlevel_q <= '0;
            status_q <= RD_STATUS_RESET;
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            rlevel_q <= rlevel_d;
            status_q <= status_d;
        end
    end

    assign mem_ren       = ren;
    assign raddr         = rbin_q[ADDR_SIZE-1:0];
    assign rptr_gray     = rgray_q;
    assign rempty        = (FWFT != 0) ? ~status_q.valid : status_q.mem_empty;
    assign rvalid        = status_q.valid;
    assign ralmost_empty = status_q.almost_empty;
    assign rlevel        = rlevel_q;
    assign runderflow    = status_q.underflow;

endmodule

// File: tb/tb_rptr_empty_level.sv
// Bench for rptr_empty_level: standard and FWFT instances run against an integer-count model.
module tb_rptr_empty_level;

    logic clk = 1'b0;
    bit   clk_run = 1'b1;
    logic rd_rstn = 1'b1;
    logic [4:0] thr;

    logic       s_rd_en, s_mem_ren, s_rempty, s_rvalid, s_ae, s_unf;
    logic [4:0] s_wgray, s_rptr_gray, s_rlevel;
    logic [3:0] s_raddr;
    logic       f_rd_en, f_mem_ren, f_rempty, f_rvalid, f_ae, f_unf;
    logic [4:0] f_wgray, f_rptr_gray, f_rlevel;
    logic [3:0] f_raddr;

    int n_vec, n_err;

    // Model: unbounded word counts read/written, plus registered flag values.
    int s_rc, s_wc, s_lvl;
    bit s_mempty, s_ae_m, s_unf_m;
    int f_rc, f_wc, f_lvl;
    bit f_mempty, f_valid, f_ae_m, f_unf_m;

    rptr_empty_level #(.ADDR_SIZE(4), .FWFT(0)) u_std (
        .rd_clk(clk), .rd_rstn(rd_rstn), .rd_en(s_rd_en), .ae_thresh(thr),
        .wr_ptr_gray_sync(s_wgray), .mem_ren(s_mem_ren), .raddr(s_raddr),
        .rptr_gray(s_rptr_gray), .rempty(s_rempty), .rvalid(s_rvalid),
        .ralmost_empty(s_ae), .rlevel(s_rlevel), .runderflow(s_unf)
    );

    rptr_empty_level #(.ADDR_SIZE(4), .FWFT(1)) u_fwft (
        .rd_clk(clk), .rd_rstn(rd_rstn), .rd_en(f_rd_en), .ae_thresh(thr),
        .wr_ptr_gray_sync(f_wgray), .mem_ren(f_mem_ren), .raddr(f_raddr),
        .rptr_gray(f_rptr_gray), .rempty(f_rempty), .rvalid(f_rvalid),
        .ralmost_empty(f_ae), .rlevel(f_rlevel), .runderflow(f_unf)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    function automatic logic [4:0] g5(input int c);
        logic [4:0] b;
        b = c[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        s_rc = 0; s_wc = 0; s_lvl = 0; s_mempty = 1; s_ae_m = 1; s_unf_m = 0;
        f_rc = 0; f_wc = 0; f_lvl = 0; f_mempty = 1; f_valid = 0; f_ae_m = 1; f_unf_m = 0;
    endtask

    task automatic drive(input bit srd, input int swc, input bit frd, input int fwc, input int th);
        s_rd_en = srd; s_wc = swc; s_wgray = g5(swc);
        f_rd_en = frd; f_wc = fwc; f_wgray = g5(fwc);
        thr = 5'(th);
        #1;
    endtask

    task automatic check_all();
        cmp("std.mem_ren",   s_mem_ren,   32'(s_rd_en && !s_mempty));
        cmp("std.raddr",     s_raddr,     s_rc & 15);
        cmp("std.rptr_gray", s_rptr_gray, g5(s_rc));
        cmp("std.rempty",    s_rempty,    s_mempty);
        cmp("std.rvalid",    s_rvalid,    !s_mempty);
        cmp("std.almost",    s_ae,        s_ae_m);
        cmp("std.rlevel",    s_rlevel,    s_lvl);
        cmp("std.underflow", s_unf,       s_unf_m);
        cmp("fwft.mem_ren",   f_mem_ren,   32'(!f_mempty && (!f_valid || f_rd_en)));
        cmp("fwft.raddr",     f_raddr,     f_rc & 15);
        cmp("fwft.rptr_gray", f_rptr_gray, g5(f_rc));
        cmp("fwft.rempty",    f_rempty,    !f_valid);
        cmp("fwft.rvalid",    f_rvalid,    f_valid);
        cmp("fwft.almost",    f_ae,        f_ae_m);
        cmp("fwft.rlevel",    f_rlevel,    f_lvl);
        cmp("fwft.underflow", f_unf,       f_unf_m);
    endtask

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic advance();
        bit pop, ren;
        int th;
        th  = int'(thr);
        pop = s_rd_en && !s_mempty;
        if (s_rd_en && s_mempty) s_unf_m = 1;
        s_rc    += int'(pop);
        s_lvl    = (s_wc - s_rc) & 31;
        s_mempty = (s_lvl == 0);
        s_ae_m   = (s_lvl <= th);

        ren = !f_mempty && (!f_valid || f_rd_en);
        if (f_rd_en && !f_valid) f_unf_m = 1;
        f_valid  = ren || (f_valid && !f_rd_en);
        f_rc    += int'(ren);
        f_mempty = (((f_wc - f_rc) & 31) == 0);
        f_lvl    = ((f_wc - f_rc) & 31) + int'(f_valid);
        f_ae_m   = (f_lvl <= th);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit srd, input int swc, input bit frd, input int fwc, input int th);
        drive(srd, swc, frd, fwc, th);
        check_all();
        advance();
    endtask

    // Random traffic; the writer never runs more than a full FIFO ahead of the reader.
    task automatic rand_phase(input int ncyc);
        int rp, wp, thv, nsw, nfw;
        bit srd, frd;
        rp  = $urandom_range(10, 90);
        wp  = $urandom_range(10, 90);
        thv = $urandom_range(0, 16);
        for (int i = 0; i < ncyc; i++) begin
            if ($urandom_range(0, 15) == 0) thv = $urandom_range(0, 16);
            srd = ($urandom_range(0, 99) < rp);
            frd = ($urandom_range(0, 99) < rp);
            nsw = s_wc;
            nfw = f_wc;
            if ((s_wc - s_rc) < 16 && $urandom_range(0, 99) < wp) nsw++;
            if ((f_wc - f_rc + int'(f_valid)) < 16 && $urandom_range(0, 99) < wp) nfw++;
            cyc(srd, nsw, frd, nfw, thv);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ra[4];
        int cnt, runs;
        bit prev;
        exp_ra = '{14, 15, 0, 1};
        n_vec = 0; n_err = 0;
        s_rd_en = 0; f_rd_en = 0; s_wgray = '0; f_wgray = '0; thr = 5'd2;
        model_reset();

        // Reset values
        #1 rd_rstn = 1'b0;
        #1;
        cmp("rst.std.rempty", s_rempty, 1);
        cmp("rst.std.almost", s_ae, 1);
        cmp("rst.std.rlevel", s_rlevel, 0);
        cmp("rst.std.rvalid", s_rvalid, 0);
        cmp("rst.std.rptr_gray", s_rptr_gray, 0);
        cmp("rst.std.mem_ren", s_mem_ren, 0);
        cmp("rst.fwft.rempty", f_rempty, 1);
        cmp("rst.fwft.rvalid", f_rvalid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rd_rstn = 1'b1;
        advance();

        // Level 5, then drain across the almost-empty threshold of 2
        cyc(0, 5, 0, 0, 2);
        cmp("t2.rempty", s_rempty, 0);
        cmp("t2.rlevel5", s_rlevel, 5);
        cmp("t2.almost0", s_ae, 0);
        repeat (3) cyc(1, 5, 0, 0, 2);
        cmp("t2.rlevel2", s_rlevel, 2);
        cmp("t2.almost1", s_ae, 1);
        repeat (2) cyc(1, 5, 0, 0, 2);
        cmp("t2.empty", s_rempty, 1);
        cmp("t2.rlevel0", s_rlevel, 0);
        cmp("t2.raddr5", s_raddr, 5);

        // Advance the read pointer to 30, then read across the wrap
        for (int i = 0; i < 100 && s_rc < 30; i++) begin
            cyc(!s_mempty, (s_rc + 8 > 30) ? 30 : s_rc + 8, 0, 0, 2);
        end
        cmp("t3.raddr14", s_raddr, 14);
        cmp("t3.gray30", s_rptr_gray, 5'b10001);
        cyc(0, 34, 0, 0, 2);
        cmp("t3.rlevel4", s_rlevel, 4);
        for (int i = 0; i < 4; i++) begin
            drive(1, 34, 0, 0, 2);
            cmp("t3.raddr_wrap", s_raddr, exp_ra[i]);
            check_all();
            advance();
        end
        cmp("t3.gray2", s_rptr_gray, 5'b00011);
        cmp("t3.empty", s_rempty, 1);
        cmp("t3.no_underflow", s_unf, 0);

        // Reads while empty
        for (int i = 0; i < 3; i++) begin
            drive(1, 34, 0, 0, 2);
            cmp("t4.mem_ren", s_mem_ren, 0);
            check_all();
            advance();
        end
        cmp("t4.underflow", s_unf, 1);
        cmp("t4.gray_held", s_rptr_gray, 5'b00011);
        repeat (2) cyc(0, 34, 0, 0, 2);
        cmp("t4.underflow_held", s_unf, 1);

        // FWFT single word, then a 4-word burst with rd_en held
        cyc(0, 34, 0, 1, 2);
        drive(0, 34, 0, 1, 2);
        cmp("t5.mem_ren", f_mem_ren, 1);
        cmp("t5.raddr0", f_raddr, 0);
        check_all();
        advance();
        cmp("t5.rvalid1", f_rvalid, 1);
        cmp("t5.rempty0", f_rempty, 0);
        cyc(0, 34, 1, 1, 2);
        cmp("t5.rvalid0", f_rvalid, 0);
        cmp("t5.rempty1", f_rempty, 1);
        cnt = 0; runs = 0; prev = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 34, 1, 5, 2);
            if (f_rvalid === 1'b1) begin
                cnt++;
                if (!prev) runs++;
            end
            prev = (f_rvalid === 1'b1);
        end
        cmp("t5.burst_words", cnt, 4);
        cmp("t5.burst_runs", runs, 1);

        for (int ph = 0; ph < 8; ph++) rand_phase(60);

        // Asynchronous reset with the clock stopped at level 7
        cyc(0, s_rc + 7, 0, f_wc, 2);
        cyc(0, s_wc, 0, f_wc, 2);
        cmp("t6.rlevel7", s_rlevel, 7);
        clk_run = 0;
        #3 rd_rstn = 1'b0;
        #2;
        cmp("t6.std.rempty", s_rempty, 1);
        cmp("t6.std.rlevel", s_rlevel, 0);
        cmp("t6.std.almost", s_ae, 1);
        cmp("t6.std.gray", s_rptr_gray, 0);
        cmp("t6.std.raddr", s_raddr, 0);
        cmp("t6.std.underflow", s_unf, 0);
        cmp("t6.fwft.rvalid", f_rvalid, 0);
        cmp("t6.fwft.rlevel", f_rlevel, 0);
        model_reset();
        drive(0, 0, 0, 0, 2);
        #2 rd_rstn = 1'b1;
        #2 clk_run = 1;
        advance();
        cmp("t6.resume_raddr", s_raddr, 0);
        rand_phase(120);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
